// File: rtl/sprite_blitter_pkg.sv
// sprite_blitter_pkg: shared colour key, sprite size, framebuffer defaults and FSM encoding
package sprite_blitter_pkg;
    localparam logic [11:0] TRANSPARENT = 12'hF0F;
    localparam int SPR_DIM = 32;
    localparam int FB_W_DEF = 640;
    localparam int FB_H_DEF = 480;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: draw request, sprite ROM port and framebuffer write port bundle
// Optional feature macro: SPRITE_BLITTER_MIRROR_EN adds the mirror_x request bit.
interface sprite_blitter_if #(parameter int ADDR_W = 19);
    logic start;
    logic [9:0] x_pos, y_pos;
`ifdef SPRITE_BLITTER_MIRROR_EN
    logic mirror_x;
`endif
    logic busy, done;
    logic [4:0] rom_row, rom_col;
    logic [11:0] rom_data;
    logic fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [11:0] fb_wdata;
    logic fb_ready;
    modport master (
        output start, x_pos, y_pos,
`ifdef SPRITE_BLITTER_MIRROR_EN
        mirror_x,
`endif
        rom_data, fb_ready,
        input busy, done, rom_row, rom_col, fb_we, fb_addr, fb_wdata
    );
    modport slave (
        input start, x_pos, y_pos,
`ifdef SPRITE_BLITTER_MIRROR_EN
        mirror_x,
`endif
        rom_data, fb_ready,
        output busy, done, rom_row, rom_col, fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: row-major 32x32 sprite coordinate counter with optional column mirror
module sprite_addr_gen
    import sprite_blitter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    input  logic       mirror,
    output logic [4:0] row,
    output logic [4:0] col,
    output logic [4:0] rom_col,
    output logic       last
);
    assign last = (row == 5'(SPR_DIM - 1)) && (col == 5'(SPR_DIM - 1));
    assign rom_col = mirror ? 5'(SPR_DIM - 1) - col : col;
    // col counts fastest and carries into row; wraps back to (0,0) after the last pixel
    always_ff @(posedge clk or posedge reset)
        if (reset) {row, col} <= '0;
        else if (adv) {row, col} <= {row, col} + 10'd1;
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: clipped, colour-keyed 32x32 sprite copy into the framebuffer at 1 px/clk
// Optional feature macro: SPRITE_BLITTER_MIRROR_EN enables the mirror_x horizontal flip.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int ADDR_W = 19
) (
    input logic clk,
    input logic reset,
    sprite_blitter_if.slave bus
);
    state_t state, state_n;
    logic [9:0] x_q, y_q;
    logic mirror_q;
    logic [4:0] row, col;
    logic last, stall, adv, wr;
    logic b_v, b_last, o_last, skid_v;
    logic [4:0] b_row, b_col;
    logic [11:0] skid, pix;
    logic [10:0] xs, ys;

    sprite_addr_gen u_addr (
        .clk(clk), .reset(reset), .adv(adv), .mirror(mirror_q),
        .row(row), .col(col), .rom_col(bus.rom_col), .last(last)
    );

    assign bus.rom_row = row;
    assign stall = bus.fb_we & ~bus.fb_ready;
    assign adv = (state == RUN) & ~stall;
    assign pix = skid_v ? skid : bus.rom_data;
    assign xs = {1'b0, x_q} + {6'b0, b_col};
    assign ys = {1'b0, y_q} + {6'b0, b_row};
    assign wr = b_v && pix != TRANSPARENT && xs < 11'(FB_W) && ys < 11'(FB_H);
    assign bus.busy = state == RUN || state == DRAIN;
    assign bus.done = state == DONE;

`ifdef SPRITE_BLITTER_MIRROR_EN
    // flip request is captured together with the destination position
    always_ff @(posedge clk or posedge reset)
        if (reset) mirror_q <= 1'b0;
        else if (state == IDLE && bus.start) mirror_q <= bus.mirror_x;
`else
    assign mirror_q = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // RUN ends once the last address moves into the ROM; DRAIN ends when that pixel leaves the output reg
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? RUN : IDLE;
            RUN:     state_n = (adv && last) ? DRAIN : RUN;
            DRAIN:   state_n = (!stall && o_last) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // ROM stage, skid and output register advance together; a stall freezes them and parks the ROM word
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            b_v <= 1'b0;
            b_last <= 1'b0;
            b_row <= '0;
            b_col <= '0;
            skid_v <= 1'b0;
            skid <= '0;
            o_last <= 1'b0;
            bus.fb_we <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_wdata <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                x_q <= bus.x_pos;
                y_q <= bus.y_pos;
            end
            if (stall) begin
                if (!skid_v) skid <= bus.rom_data;
                skid_v <= 1'b1;
            end else begin
                skid_v <= 1'b0;
                b_v <= adv;
                b_last <= last;
                b_row <= row;
                b_col <= col;
                o_last <= b_v & b_last;
                bus.fb_we <= wr;
                if (wr) begin
                    bus.fb_addr <= ADDR_W'(ys) * ADDR_W'(FB_W) + ADDR_W'(xs);
                    bus.fb_wdata <= pix;
                end
            end
        end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized scoreboard bench for sprite_blitter
`timescale 1ns/1ps
module tb_sprite_blitter;
    import sprite_blitter_pkg::*;

    typedef struct packed {
        logic [18:0] addr;
        logic [11:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0, checks = 0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int ready_pct = 100, rom_mode = 0;
    logic [11:0] rom_mem [1024];
    wr_t exp_q[$];
    logic prev_stall = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [11:0] prev_data = '0;

    sprite_blitter_if #(.ADDR_W(19)) bus();

    sprite_blitter #(.FB_W(640), .FB_H(480), .ADDR_W(19)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] rom_val(input logic [4:0] r, input logic [4:0] c);
        if (rom_mode == 0) return {r, c, 2'b00};
        if (rom_mode == 1) return (r[0] ^ c[0]) ? TRANSPARENT : {r, c, 2'b00};
        return rom_mem[{r, c}];
    endfunction

    // sprite ROM: registered address, data one clock later
    always @(posedge clk) bus.rom_data <= rom_val(bus.rom_row, bus.rom_col);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // reference: every sprite pixel in row-major order, skipped when keyed or off-screen
    task automatic build(input int x, input int y, input bit mir);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                logic [11:0] d;
                d = rom_val(5'(r), 5'(mir ? 31 - c : c));
                if (d != 12'hF0F && x + c < 640 && y + r < 480)
                    exp_q.push_back('{addr: 19'((y + r) * 640 + x + c), data: d});
            end
    endtask

    // monitor: checks every accepted write against the scoreboard and the hold rule while stalled
    always @(negedge clk) begin
        if (reset) prev_stall <= 1'b0;
        else begin
            if (prev_stall) begin
                check("stall_we", 32'(bus.fb_we), 32'd1);
                check("stall_addr", 32'(bus.fb_addr), 32'(prev_addr));
                check("stall_data", 32'(bus.fb_wdata), 32'(prev_data));
            end
            if (bus.fb_we && bus.fb_ready) begin
                if (exp_q.size() == 0) check("extra_write", 32'(bus.fb_addr), 32'hFFFF_FFFF);
                else begin
                    check("wr_addr", 32'(bus.fb_addr), 32'(exp_q[0].addr));
                    check("wr_data", 32'(bus.fb_wdata), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            prev_stall <= bus.fb_we && !bus.fb_ready;
            prev_addr <= bus.fb_addr;
            prev_data <= bus.fb_wdata;
        end
    end

    // framebuffer back-pressure, changed just after each edge
    initial forever begin
        @(posedge clk);
        #1 bus.fb_ready = ($urandom_range(0, 99) < ready_pct);
    end

    task automatic run(input int x, input int y, input bit mir, input int poke, input bit lat, input int want);
        int d0, w0, n, exp_n;
        d0 = done_cnt;
        w0 = wr_cnt;
        n = 0;
        build(x, y, mir);
        exp_n = exp_q.size();
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_pos = 10'(x);
        bus.y_pos = 10'(y);
`ifdef SPRITE_BLITTER_MIRROR_EN
        bus.mirror_x = mir;
`endif
        @(posedge clk);
        #1 bus.start = 1'b0;
        start_cyc = cyc;
        @(negedge clk);
        #1 check("busy", 32'(bus.busy), 32'd1);
        while (done_cnt == d0 && n < 20000) begin
            @(negedge clk);
            #1 n++;
            if (n == poke) begin
                bus.start = 1'b1;
                bus.x_pos = 10'd3;
                bus.y_pos = 10'd3;
            end else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("done_count", 32'(done_cnt - d0), 32'd1);
        if (lat) check("done_latency", 32'(done_cyc - start_cyc), 32'd1026);
        check("write_count", 32'(wr_cnt - w0), 32'(want >= 0 ? want : exp_n));
        check("pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_we"}, 32'(bus.fb_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.fb_addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.fb_wdata), 32'd0);
        check({tag, "_rom_row"}, 32'(bus.rom_row), 32'd0);
        check({tag, "_rom_col"}, 32'(bus.rom_col), 32'd0);
    endtask

    initial begin
        int d0, w0, n;
        bus.start = 1'b0;
        bus.x_pos = '0;
        bus.y_pos = '0;
        bus.fb_ready = 1'b1;
`ifdef SPRITE_BLITTER_MIRROR_EN
        bus.mirror_x = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        rom_mode = 0;
        run(0, 0, 0, 0, 1, 1024);
        rom_mode = 1;
        run(0, 0, 0, 0, 1, 512);
        rom_mode = 0;
        run(620, 470, 0, 0, 1, 200);
        run(639, 479, 0, 0, 1, 1);
        ready_pct = 50;
        run(0, 0, 0, 0, 0, 1024);
        ready_pct = 70;
        rom_mode = 2;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 1024; k++)
                rom_mem[k] = ($urandom_range(0, 3) == 0) ? TRANSPARENT : 12'($urandom);
            run(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 0, 0, 0, -1);
        end
        rom_mode = 0;
        ready_pct = 100;
        build(0, 0, 0);
        d0 = done_cnt;
        w0 = wr_cnt;
        n = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_pos = '0;
        bus.y_pos = '0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (wr_cnt - w0 < 300 && n < 5000) begin
            @(negedge clk);
            #1 n++;
        end
        check("abort_point", 32'(wr_cnt - w0), 32'd300);
        reset = 1'b1;
        @(negedge clk);
        #1 check_idle("abort");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run(0, 0, 0, 0, 1, 1024);
        run(100, 50, 0, 100, 1, 1024);
`ifdef SPRITE_BLITTER_MIRROR_EN
        run(0, 0, 1, 0, 1, 1024);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
